// File: rtl/vector_ls_engine_pkg.sv
// Shared types and sizing helpers for the vector load/store engine.
// Optional feature macro used by the engine: VLS_ENGINE_ERR_EN.
package vector_ls_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int SCALAR_BYTES = 4;

  function automatic int calc_num_scalars(input int slices, input int elems,
                                          input int elem_size, input int scalar_size);
    return elems * elem_size / scalar_size * slices;
  endfunction

  function automatic int calc_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_ls_engine_if.sv
// Control handshake between the vector load/store controller (master)
// and the executing engine (slave).
interface vector_ls_engine_if
  import vector_ls_engine_pkg::*;
#(
  parameter int CW = calc_cnt_width(4)
);
  logic          new_op;
  logic          we;
  logic          store_en;
  logic [CW-1:0] count;
  logic [31:0]   g;
  logic          complete;

  modport master (output new_op, we, store_en, count, g, input complete);
  modport slave  (input new_op, we, store_en, count, g, output complete);
endinterface

// File: rtl/vector_ls_engine_addr_gen.sv
// Scalar index counter and byte-address generator for one load/store operation;
// last_o flags the final scalar of the operation.
module vector_ls_engine_addr_gen
  import vector_ls_engine_pkg::*;
#(
  parameter int IW = 2,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [31:0]   base_i,
  input  logic [CW-1:0] count_i,
  output logic [IW-1:0] idx_o,
  output logic [31:0]   addr_o,
  output logic          last_o
);
  logic [IW-1:0] idx_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] n_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      addr_q <= '0;
      n_q    <= '0;
    end else if (start_i) begin
      idx_q  <= '0;
      addr_q <= base_i;
      n_q    <= count_i;
    end else if (step_i) begin
      idx_q  <= idx_q + IW'(1);
      // Address wraps modulo 2^32 by design.
      addr_q <= addr_q + 32'(SCALAR_BYTES);
    end
  end

  assign idx_o  = idx_q;
  assign addr_o = addr_q;
  assign last_o = ((CW'(idx_q) + CW'(1)) == n_q);
endmodule

// File: rtl/vector_ls_engine.sv
// Vector load/store engine: moves count scalars between the vector register file
// and a single-beat data bus. Optional bus-error abort: define VLS_ENGINE_ERR_EN.
module vector_ls_engine
  import vector_ls_engine_pkg::*;
#(
  parameter int   NUM_SLICES  = 1,
  parameter int   NUM_ELEMS   = 8,
  parameter int   ELEM_SIZE   = 16,
  parameter int   SCALAR_SIZE = 32,
  localparam int  NS = calc_num_scalars(NUM_SLICES, NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE),
  localparam int  IW = calc_idx_width(NS),
  localparam int  CW = calc_cnt_width(NS)
) (
  input  logic            clk,
  input  logic            reset_n,
  vector_ls_engine_if.slave ctrl,
  output logic            vreg_re,
  output logic [IW-1:0]   vreg_ridx,
  input  logic [31:0]     vreg_rdata,
  output logic            vreg_we,
  output logic [IW-1:0]   vreg_widx,
  output logic [31:0]     vreg_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_err
`ifdef VLS_ENGINE_ERR_EN
  ,
  output logic            err_sticky
`endif
);
  state_t        state_q, state_d;
  logic          op_q;       // 1 = store
  logic          fetch_q;    // register-file read data is valid this cycle
  logic [31:0]   wdata_q;
  logic          start, step, last, beat_err, access;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt_clamped;

  assign cnt_clamped = (ctrl.count > CW'(NS)) ? CW'(NS) : ctrl.count;
  assign access      = (state_q == S_ACCESS);

`ifdef VLS_ENGINE_ERR_EN
  logic err_sticky_q;
  assign beat_err   = mem_err;
  assign err_sticky = err_sticky_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           err_sticky_q <= 1'b0;
    else if (start)                         err_sticky_q <= 1'b0;
    else if (access && mem_ack && mem_err)  err_sticky_q <= 1'b1;
  end
`else
  assign beat_err = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ctrl.we, mem_err};

  vector_ls_engine_addr_gen #(.IW(IW), .CW(CW)) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (start),
    .step_i  (step),
    .base_i  (ctrl.g),
    .count_i (cnt_clamped),
    .idx_o   (idx),
    .addr_o  (mem_addr),
    .last_o  (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      fetch_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= (state_q == S_FETCH);
      if (start)   op_q    <= ctrl.store_en;
      if (fetch_q) wdata_q <= vreg_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl.new_op) begin
          start = 1'b1;
          if (cnt_clamped == '0) state_d = S_DONE;
          else if (ctrl.store_en) state_d = S_FETCH;
          else                    state_d = S_ACCESS;
        end
      end
      S_FETCH:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (mem_ack) begin
          step = 1'b1;
          if (beat_err || last) state_d = S_DONE;
          else if (op_q)        state_d = S_FETCH;
          else                  state_d = S_ACCESS;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = state_t'(2'bxx);
    endcase
  end

  // Read data arrives one cycle after vreg_re; forward it on the first access cycle.
  assign mem_wdata     = fetch_q ? vreg_rdata : wdata_q;
  assign mem_req       = access;
  assign mem_we        = access & op_q;
  assign mem_be        = 4'hf;
  assign vreg_re       = (state_q == S_FETCH);
  assign vreg_ridx     = idx;
  assign vreg_we       = access & mem_ack & ~op_q & ~beat_err;
  assign vreg_widx     = idx;
  assign vreg_wdata    = mem_rdata;
  assign ctrl.complete = (state_q == S_DONE);

  a_new_op_idle: assert property (@(posedge clk) disable iff (!reset_n)
                                  ctrl.new_op |-> (state_q == S_IDLE));
endmodule

// File: tb/tb_vector_ls_engine.sv
// Directed bench for vector_ls_engine with a 16-element slice (8 scalars).
module tb_vector_ls_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vreg_re, vreg_we, mem_req, mem_we, mem_ack, mem_err;
  logic [2:0]  vreg_ridx, vreg_widx;
  logic [31:0] vreg_rdata = '0;
  logic [31:0] vreg_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef VLS_ENGINE_ERR_EN
  logic        err_sticky;
`endif

  int total = 0;
  int bad = 0;
  int ack_wait = 0;
  int wait_cnt = 0;
  int ack_total = 0;
  int comp_cnt = 0;
  int err_base = 0;
  int err_beat = 0;
  bit err_en = 1'b0;

  logic [31:0] req_addr[$], req_wdata[$], ack_addr[$], wr_data[$];
  logic        req_we[$];
  logic [2:0]  wr_idx[$];

  vector_ls_engine_if #(.CW(4)) ctrl ();

  vector_ls_engine #(.NUM_SLICES(1), .NUM_ELEMS(16), .ELEM_SIZE(16), .SCALAR_SIZE(32)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl),
    .vreg_re(vreg_re), .vreg_ridx(vreg_ridx), .vreg_rdata(vreg_rdata),
    .vreg_we(vreg_we), .vreg_widx(vreg_widx), .vreg_wdata(vreg_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
`ifdef VLS_ENGINE_ERR_EN
    , .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt >= ack_wait);
  assign mem_rdata = mem_addr + 32'hA000_0000;
  assign mem_err   = err_en && mem_req && ((ack_total - err_base) == err_beat);

  // Register file read model: scalar i holds C0DE_000i.
  always @(posedge clk) begin
    if (vreg_re) vreg_rdata <= 32'hC0DE_0000 | {29'b0, vreg_ridx};
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req) begin
      req_addr.push_back(mem_addr);
      req_wdata.push_back(mem_wdata);
      req_we.push_back(mem_we);
    end
    if (mem_req && mem_ack) begin
      ack_addr.push_back(mem_addr);
      ack_total <= ack_total + 1;
    end
    if (vreg_we) begin
      wr_idx.push_back(vreg_widx);
      wr_data.push_back(vreg_wdata);
    end
    if (ctrl.complete) comp_cnt <= comp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic st, input logic [3:0] cnt,
                        input logic [31:0] base, input int wt, input int exp_lat);
    int lat;
    int c0;
    bit done;
    ack_wait = wt;
    c0 = comp_cnt;
    @(negedge clk);
    ctrl.new_op = 1'b1; ctrl.store_en = st; ctrl.we = st; ctrl.count = cnt; ctrl.g = base;
    lat = 0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      ctrl.new_op = 1'b0;
      lat++;
      if (ctrl.complete) done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_complete_one_cycle"}, 32'(ctrl.complete), 32'd0);
    chk({tag, "_complete_pulses"}, 32'(comp_cnt - c0), 32'd1);
    $display("op %s store=%0d count=%0d g=%h latency=%0d", tag, st, cnt, base, lat);
  endtask

  initial begin
    int rb, ab, wb, c0;
    ctrl.new_op = 1'b0; ctrl.we = 1'b0; ctrl.store_en = 1'b0; ctrl.count = '0; ctrl.g = '0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_vreg_re", 32'(vreg_re), 32'd0);
    chk("rst_vreg_we", 32'(vreg_we), 32'd0);
    chk("rst_complete", 32'(ctrl.complete), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'hf);
    @(negedge clk);
    reset_n = 1'b1;

    // Load 8 scalars from 0x1000, ack in the same cycle
    rb = req_addr.size(); wb = wr_idx.size();
    run_op("load8", 1'b0, 4'd8, 32'h1000, 0, 9);
    chk("load8_reqs", 32'(req_addr.size() - rb), 32'd8);
    chk("load8_writes", 32'(wr_idx.size() - wb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("load8_addr%0d", i), req_addr[rb+i], 32'h1000 + 32'(4*i));
      chk($sformatf("load8_we%0d", i), 32'(req_we[rb+i]), 32'd0);
      chk($sformatf("load8_widx%0d", i), 32'(wr_idx[wb+i]), 32'(i));
      chk($sformatf("load8_wdata%0d", i), wr_data[wb+i], 32'hA000_1000 + 32'(4*i));
    end

    // Store 4 scalars to 0x2000, three wait cycles per beat
    rb = req_addr.size(); wb = wr_idx.size(); ab = ack_addr.size();
    run_op("store4", 1'b1, 4'd4, 32'h2000, 3, 21);
    chk("store4_req_cycles", 32'(req_addr.size() - rb), 32'd16);
    chk("store4_acks", 32'(ack_addr.size() - ab), 32'd4);
    chk("store4_no_vreg_we", 32'(wr_idx.size() - wb), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("store4_addr_c%0d", k), req_addr[rb+k], 32'h2000 + 32'(4*(k/4)));
      chk($sformatf("store4_wdata_c%0d", k), req_wdata[rb+k], 32'hC0DE_0000 + 32'(k/4));
      chk($sformatf("store4_we_c%0d", k), 32'(req_we[rb+k]), 32'd1);
    end

    // Zero count: no bus traffic
    rb = req_addr.size();
    run_op("count0", 1'b0, 4'd0, 32'h3000, 0, 1);
    chk("count0_no_req", 32'(req_addr.size() - rb), 32'd0);

    // Address wrap past 2^32
    rb = req_addr.size();
    run_op("wrap", 1'b0, 4'd4, 32'hFFFF_FFF8, 0, 5);
    chk("wrap_a0", req_addr[rb+0], 32'hFFFF_FFF8);
    chk("wrap_a1", req_addr[rb+1], 32'hFFFF_FFFC);
    chk("wrap_a2", req_addr[rb+2], 32'h0000_0000);
    chk("wrap_a3", req_addr[rb+3], 32'h0000_0004);

    // Count above capacity is clamped to 8
    rb = req_addr.size();
    run_op("clamp", 1'b0, 4'd15, 32'h3000, 0, 9);
    chk("clamp_reqs", 32'(req_addr.size() - rb), 32'd8);
    chk("clamp_last_addr", req_addr[rb+7], 32'h301C);

    // Reset during the third beat of a store
    c0 = comp_cnt;
    ack_wait = 0;
    @(negedge clk);
    ctrl.new_op = 1'b1; ctrl.store_en = 1'b1; ctrl.we = 1'b1; ctrl.count = 4'd4; ctrl.g = 32'h4000;
    @(negedge clk);
    ctrl.new_op = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    chk("midrst_addr_before", mem_addr, 32'h4008);
    reset_n = 1'b0;
    #1;
    chk("midrst_req_dropped", 32'(mem_req), 32'd0);
    chk("midrst_we_dropped", 32'(mem_we), 32'd0);
    chk("midrst_vreg_re", 32'(vreg_re), 32'd0);
    $display("op midrst reset asserted mid-store mem_req=%0d", mem_req);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_complete", 32'(comp_cnt - c0), 32'd0);
    chk("midrst_addr_cleared", mem_addr, 32'd0);
    rb = req_addr.size();
    run_op("after_rst", 1'b0, 4'd2, 32'h5000, 0, 3);
    chk("after_rst_a0", req_addr[rb+0], 32'h5000);
    chk("after_rst_a1", req_addr[rb+1], 32'h5004);

`ifdef VLS_ENGINE_ERR_EN
    chk("err_sticky_clear", 32'(err_sticky), 32'd0);
    wb = wr_idx.size(); ab = ack_addr.size();
    err_base = ack_total;
    err_beat = 2;
    err_en = 1'b1;
    run_op("err", 1'b0, 4'd8, 32'h6000, 0, 4);
    err_en = 1'b0;
    chk("err_vreg_writes", 32'(wr_idx.size() - wb), 32'd2);
    chk("err_acks", 32'(ack_addr.size() - ab), 32'd3);
    chk("err_sticky_set", 32'(err_sticky), 32'd1);
    run_op("err_clear", 1'b0, 4'd1, 32'h7000, 0, 2);
    chk("err_sticky_cleared", 32'(err_sticky), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
